// File: rtl/u712_pkg.sv
// Shared definitions for the U712 68000-style bus responder: state encoding
// and the default timing parameters.
package u712_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        STROBE  = 3'd1,
        ACCESS  = 3'd2,
        WAITACK = 3'd3,
        ALIGN   = 3'd4,
        DTACK   = 3'd5,
        TERM    = 3'd6,
        ERR     = 3'd7
    } resp_state_t;

    localparam int WAIT_STATES_DEF = 0;
    localparam int TIMEOUT_DEF     = 200;

endpackage

// File: rtl/u712_sync2.sv
// Two-flop synchronizer bank on the falling clock edge; resets to all ones so
// that active-low strobes start out negated.
module u712_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             RESETn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic [1:0] stage_reg;

        always_ff @(negedge clk) begin
            if (!RESETn) begin
                stage_reg <= 2'b11;
            end else begin
                stage_reg <= {stage_reg[0], d[gi]};
            end
        end

        assign q[gi] = stage_reg[1];
    end

endmodule

// File: rtl/u712_m68k_resp.sv
// 68000-style bus responder: turns asynchronous master strobes into single-cycle
// local register strobes and returns DTACKn aligned to the C1/C3 phase window.
module u712_m68k_resp
    import u712_pkg::*;
#(
    parameter int WAIT_STATES = WAIT_STATES_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF
) (
    input  logic        CLK80,
    input  logic        RESETn,
    input  logic        C1,
    input  logic        C3,
    input  logic        ASn,
    input  logic        UDSn,
    input  logic        LDSn,
    input  logic        RnW,
    input  logic        SELn,
    input  logic [6:0]  ADDR,
    input  logic [15:0] DIN,
    output logic [15:0] DOUT,
    output logic        DOEn,
    output logic        DTACKn,
    output logic        BERRn,
    output logic [6:0]  REG_ADDR,
    output logic [15:0] REG_WDATA,
    output logic [1:0]  REG_BE,
    output logic        REG_WR,
    output logic        REG_RD,
    input  logic        REG_ACK,
    input  logic [15:0] REG_RDATA
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    localparam logic [1:0] WS_LAST = 2'(WAIT_STATES);

    logic [4:0] sync_q;
    logic       c1_s, c3_s, as_s, uds_s, lds_s;
    logic       win_s, win_rise;

    u712_sync2 #(.WIDTH(5)) u_sync (
        .clk    (CLK80),
        .RESETn (RESETn),
        .d      ({C1, C3, ASn, UDSn, LDSn}),
        .q      (sync_q)
    );

    assign {c1_s, c3_s, as_s, uds_s, lds_s} = sync_q;

    resp_state_t state_reg, state_next;
    logic [7:0]  to_cnt_reg, to_cnt_next;
    logic [1:0]  ws_cnt_reg, ws_cnt_next;
    logic        win_prev_reg;
    logic        rnw_reg, rnw_next;
    logic [6:0]  addr_reg, addr_next;
    logic [15:0] wdata_reg, wdata_next;
    logic [1:0]  be_reg, be_next;
    logic [15:0] dout_reg, dout_next;
    logic        dtack_n_reg, berr_n_reg, doe_n_reg;
    logic        reg_wr_reg, reg_rd_reg;

    // Only the rising edge of the C1&C3 window counts, since one window spans many CLK80 cycles.
    assign win_s    = c1_s & c3_s;
    assign win_rise = win_s & ~win_prev_reg;

    always_comb begin
        state_next  = state_reg;
        to_cnt_next = to_cnt_reg;
        ws_cnt_next = ws_cnt_reg;
        rnw_next    = rnw_reg;
        addr_next   = addr_reg;
        wdata_next  = wdata_reg;
        be_next     = be_reg;
        dout_next   = dout_reg;

        case (state_reg)
            IDLE: begin
                to_cnt_next = 8'd0;
                ws_cnt_next = 2'd0;
                if (!as_s && !SELn) begin
                    state_next = STROBE;
                end
            end
            STROBE: begin
                if (as_s) begin
                    state_next = IDLE;
                end else if (!uds_s || !lds_s) begin
                    state_next = ACCESS;
                    rnw_next   = RnW;
                    addr_next  = ADDR;
                    wdata_next = DIN;
                    be_next    = {~uds_s, ~lds_s};
                end
            end
            ACCESS, WAITACK: begin
                if (to_cnt_reg != 8'hFF) begin
                    to_cnt_next = to_cnt_reg + 8'd1;
                end
                if (as_s) begin
                    state_next = IDLE;
                end else if (REG_ACK) begin
                    if (rnw_reg) begin
                        dout_next = REG_RDATA;
                    end
                    state_next = ALIGN;
                end else if (to_cnt_reg >= TO_LAST) begin
                    state_next = ERR;
                end else begin
                    state_next = WAITACK;
                end
            end
            ALIGN: begin
                if (as_s) begin
                    state_next = IDLE;
                end else if (win_rise) begin
                    if (ws_cnt_reg == WS_LAST) begin
                        state_next = DTACK;
                    end else begin
                        ws_cnt_next = ws_cnt_reg + 2'd1;
                    end
                end
            end
            DTACK: begin
                if (as_s) begin
                    state_next = TERM;
                end
            end
            TERM: begin
                state_next = IDLE;
            end
            ERR: begin
                if (as_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bus-side outputs are registered from the next state so they never glitch.
    always_ff @(negedge CLK80) begin
        if (!RESETn) begin
            state_reg    <= IDLE;
            to_cnt_reg   <= 8'd0;
            ws_cnt_reg   <= 2'd0;
            win_prev_reg <= 1'b1;
            rnw_reg      <= 1'b1;
            addr_reg     <= 7'd0;
            wdata_reg    <= 16'd0;
            be_reg       <= 2'b00;
            dout_reg     <= 16'd0;
            dtack_n_reg  <= 1'b1;
            berr_n_reg   <= 1'b1;
            doe_n_reg    <= 1'b1;
            reg_wr_reg   <= 1'b0;
            reg_rd_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            to_cnt_reg   <= to_cnt_next;
            ws_cnt_reg   <= ws_cnt_next;
            win_prev_reg <= win_s;
            rnw_reg      <= rnw_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            be_reg       <= be_next;
            dout_reg     <= dout_next;
            dtack_n_reg  <= (state_next != DTACK);
            berr_n_reg   <= (state_next != ERR);
            doe_n_reg    <= !((state_next == DTACK) && rnw_next);
            reg_wr_reg   <= (state_next == ACCESS) && !rnw_next;
            reg_rd_reg   <= (state_next == ACCESS) && rnw_next;
        end
    end

    assign DOUT      = dout_reg;
    assign DOEn      = doe_n_reg;
    assign DTACKn    = dtack_n_reg;
    assign BERRn     = berr_n_reg;
    assign REG_ADDR  = addr_reg;
    assign REG_WDATA = wdata_reg;
    assign REG_BE    = be_reg;
    assign REG_WR    = reg_wr_reg;
    assign REG_RD    = reg_rd_reg;

endmodule

// File: tb/tb_u712_m68k_resp.sv
// Directed bench for u712_m68k_resp: table of bus cycles plus hand sequences
// for timeout, wait states, abort and reset during DTACKn.
module tb_u712_m68k_resp;
    import u712_pkg::*;

    logic        CLK80 = 1'b0;
    logic        RESETn = 1'b0;
    logic        C1 = 1'b0, C3 = 1'b0;
    logic        ASn = 1'b1, UDSn = 1'b1, LDSn = 1'b1, RnW = 1'b1, SELn = 1'b1;
    logic [6:0]  ADDR = 7'd0;
    logic [15:0] DIN = 16'd0;
    logic        REG_ACK = 1'b0;
    logic [15:0] REG_RDATA = 16'd0;

    logic [15:0] dout0, dout2, wdata0, wdata2;
    logic        doe0_n, dtack0_n, berr0_n, reg_wr0, reg_rd0;
    logic        doe2_n, dtack2_n, berr2_n, reg_wr2, reg_rd2;
    logic [6:0]  addr0, addr2;
    logic [1:0]  be0, be2;

    always #5 CLK80 = ~CLK80;

    u712_m68k_resp #(.WAIT_STATES(0), .TIMEOUT(200)) u_dut0 (
        .CLK80(CLK80), .RESETn(RESETn), .C1(C1), .C3(C3), .ASn(ASn), .UDSn(UDSn),
        .LDSn(LDSn), .RnW(RnW), .SELn(SELn), .ADDR(ADDR), .DIN(DIN), .DOUT(dout0),
        .DOEn(doe0_n), .DTACKn(dtack0_n), .BERRn(berr0_n), .REG_ADDR(addr0),
        .REG_WDATA(wdata0), .REG_BE(be0), .REG_WR(reg_wr0), .REG_RD(reg_rd0),
        .REG_ACK(REG_ACK), .REG_RDATA(REG_RDATA)
    );

    u712_m68k_resp #(.WAIT_STATES(2), .TIMEOUT(200)) u_dut2 (
        .CLK80(CLK80), .RESETn(RESETn), .C1(C1), .C3(C3), .ASn(ASn), .UDSn(UDSn),
        .LDSn(LDSn), .RnW(RnW), .SELn(SELn), .ADDR(ADDR), .DIN(DIN), .DOUT(dout2),
        .DOEn(doe2_n), .DTACKn(dtack2_n), .BERRn(berr2_n), .REG_ADDR(addr2),
        .REG_WDATA(wdata2), .REG_BE(be2), .REG_WR(reg_wr2), .REG_RD(reg_rd2),
        .REG_ACK(REG_ACK), .REG_RDATA(REG_RDATA)
    );

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0, rd_cnt = 0, both_low = 0, doe_wr = 0, dtack_low0 = 0;

    // Free-running monitors sampled mid-cycle (registers move on the falling edge).
    always @(posedge CLK80) begin
        if (RESETn) begin
            if (reg_wr0) wr_cnt <= wr_cnt + 1;
            if (reg_rd0) rd_cnt <= rd_cnt + 1;
            if ((!dtack0_n && !berr0_n) || (!dtack2_n && !berr2_n)) both_low <= both_low + 1;
            if (!doe0_n && !RnW) doe_wr <= doe_wr + 1;
            if (!dtack0_n) dtack_low0 <= dtack_low0 + 1;
        end
    end

    typedef struct {
        logic        rnw;
        logic [6:0]  addr;
        logic [15:0] din;
        logic        udsn;
        logic        ldsn;
        logic [15:0] rdata;
        int          ack_dly;
        logic [1:0]  exp_be;
        logic [15:0] exp_dout;
        int          exp_wr;
        int          exp_rd;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK80);
        #1;
    endtask

    task automatic window_pulse();
        C1 = 1'b1; C3 = 1'b1;
        tick(2);
        C1 = 1'b0; C3 = 1'b0;
        tick(4);
    endtask

    task automatic release_bus();
        ASn = 1'b1; UDSn = 1'b1; LDSn = 1'b1; SELn = 1'b1;
    endtask

    task automatic start_cycle(input logic rnw, input logic [6:0] a, input logic [15:0] d,
                               input logic udsn, input logic ldsn, output bit seen);
        RnW = rnw; ADDR = a; DIN = d; SELn = 1'b0; ASn = 1'b0;
        tick(1);
        UDSn = udsn; LDSn = ldsn;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (reg_wr0 || reg_rd0) begin
                seen = 1;
                break;
            end
        end
    endtask

    task automatic bus_cycle(input vec_t v, input int idx);
        int  wr0, rd0;
        bit  seen, hit;
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        start_cycle(v.rnw, v.addr, v.din, v.udsn, v.ldsn, seen);
        chk("local_strobe_seen", 32'(seen), 32'd1);
        if (v.ack_dly > 0) tick(v.ack_dly);
        REG_RDATA = v.rdata; REG_ACK = 1'b1;
        tick(1);
        REG_ACK = 1'b0; REG_RDATA = 16'hDEAD;
        tick(4);
        chk("dtack_before_window", 32'(dtack0_n), 32'd1);
        C1 = 1'b1; C3 = 1'b1;
        tick(2);
        C1 = 1'b0; C3 = 1'b0;
        hit = 0;
        for (int k = 0; k < 8; k++) begin
            if (!dtack0_n) begin
                hit = 1;
                break;
            end
            tick(1);
        end
        chk("dtack_asserted", 32'(hit), 32'd1);
        chk("doe_with_dtack", 32'(doe0_n), v.rnw ? 32'd0 : 32'd1);
        chk("berr_with_dtack", 32'(berr0_n), 32'd1);
        chk("reg_addr", 32'(addr0), 32'(v.addr));
        chk("reg_be", 32'(be0), 32'(v.exp_be));
        chk("reg_wdata", 32'(wdata0), 32'(v.din));
        chk("dout", 32'(dout0), 32'(v.exp_dout));
        chk("wr_pulses", 32'(wr_cnt - wr0), 32'(v.exp_wr));
        chk("rd_pulses", 32'(rd_cnt - rd0), 32'(v.exp_rd));
        release_bus();
        hit = 0;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            if (dtack0_n) begin
                hit = 1;
                break;
            end
        end
        chk("dtack_released", 32'(hit), 32'd1);
        chk("doe_released", 32'(doe0_n), 32'd1);
        tick(3);
        $display("txn %0d: %s addr=%02h be=%b dout=%04h wdata=%04h", idx,
                 v.rnw ? "read " : "write", addr0, be0, dout0, wdata0);
    endtask

    initial begin
        vec_t follow;
        bit   seen, hit;
        int   n, dl0;

        //          rnw   addr   din      uds   lds   rdata    dly be     dout     wr rd
        vecs[0] = '{1'b0, 7'h12, 16'hA5C3, 1'b0, 1'b0, 16'h0000, 2, 2'b11, 16'h0000, 1, 0};
        vecs[1] = '{1'b1, 7'h05, 16'h0000, 1'b1, 1'b0, 16'h00FE, 0, 2'b01, 16'h00FE, 0, 1};
        vecs[2] = '{1'b1, 7'h7F, 16'h1111, 1'b0, 1'b1, 16'hBEEF, 1, 2'b10, 16'hBEEF, 0, 1};
        vecs[3] = '{1'b0, 7'h00, 16'h1234, 1'b1, 1'b0, 16'h5555, 3, 2'b01, 16'hBEEF, 1, 0};
        vecs[4] = '{1'b1, 7'h40, 16'h0F0F, 1'b0, 1'b0, 16'h8001, 5, 2'b11, 16'h8001, 0, 1};
        follow  = '{1'b1, 7'h33, 16'h2222, 1'b1, 1'b0, 16'h0F0F, 1, 2'b01, 16'h0F0F, 0, 1};

        // Reset values
        tick(3);
        chk("rst_dtack", 32'(dtack0_n), 32'd1);
        chk("rst_berr", 32'(berr0_n), 32'd1);
        chk("rst_doe", 32'(doe0_n), 32'd1);
        chk("rst_wr_rd", {30'd0, reg_wr0, reg_rd0}, 32'd0);
        chk("rst_dout", 32'(dout0), 32'd0);
        chk("rst_addr_be", {23'd0, addr0, be0}, 32'd0);
        chk("rst_wdata", 32'(wdata0), 32'd0);
        RESETn = 1'b1;
        tick(3);

        for (int i = 0; i < 5; i++) bus_cycle(vecs[i], i);

        // Abort: ASn negates while waiting for the local ack; late ack must be discarded.
        dl0 = dtack_low0;
        start_cycle(1'b0, 7'h2A, 16'hCAFE, 1'b0, 1'b0, seen);
        chk("abort_strobe_seen", 32'(seen), 32'd1);
        tick(3);
        release_bus();
        tick(6);
        REG_ACK = 1'b1;
        tick(1);
        REG_ACK = 1'b0;
        window_pulse();
        chk("abort_no_dtack", 32'(dtack_low0 - dl0), 32'd0);
        chk("abort_state_idle", 32'(u_dut0.state_reg), 32'(IDLE));
        $display("txn abort: dtack_low_cycles=%0d", dtack_low0 - dl0);
        bus_cycle(follow, 5);

        // WAIT_STATES=2: DTACKn only on the third window after the ack.
        start_cycle(1'b1, 7'h21, 16'h0000, 1'b0, 1'b0, seen);
        chk("ws_strobe_seen", 32'(seen), 32'd1);
        REG_RDATA = 16'hC0DE; REG_ACK = 1'b1;
        tick(1);
        REG_ACK = 1'b0;
        tick(4);
        chk("ws2_no_dtack_0", 32'(dtack2_n), 32'd1);
        window_pulse();
        chk("ws0_dtack_win1", 32'(dtack0_n), 32'd0);
        chk("ws2_no_dtack_1", 32'(dtack2_n), 32'd1);
        window_pulse();
        chk("ws2_no_dtack_2", 32'(dtack2_n), 32'd1);
        window_pulse();
        chk("ws2_dtack_win3", 32'(dtack2_n), 32'd0);
        chk("ws2_doe", 32'(doe2_n), 32'd0);
        chk("ws2_dout", 32'(dout2), 32'hC0DE);
        release_bus();
        tick(6);
        chk("ws2_dtack_released", 32'(dtack2_n), 32'd1);
        $display("txn wait-states: dout2=%04h", dout2);

        // Timeout: no local ack, BERRn exactly 200 cycles after the local strobe.
        dl0 = dtack_low0;
        start_cycle(1'b1, 7'h66, 16'h0000, 1'b1, 1'b0, seen);
        chk("to_strobe_seen", 32'(seen), 32'd1);
        n = 0;
        hit = 0;
        for (int k = 0; k < 300; k++) begin
            tick(1);
            n++;
            if (!berr0_n) begin
                hit = 1;
                break;
            end
        end
        chk("to_berr_seen", 32'(hit), 32'd1);
        chk("to_berr_latency", 32'(n), 32'd200);
        REG_ACK = 1'b1;
        tick(2);
        REG_ACK = 1'b0;
        tick(4);
        chk("to_berr_held", 32'(berr0_n), 32'd0);
        chk("to_no_dtack", 32'(dtack_low0 - dl0), 32'd0);
        release_bus();
        hit = 0;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            if (berr0_n) begin
                hit = 1;
                break;
            end
        end
        chk("to_berr_released", 32'(hit), 32'd1);
        tick(3);
        $display("txn timeout: berr latency=%0d cycles", n);

        // Reset while DTACKn is asserted.
        start_cycle(1'b1, 7'h11, 16'h0000, 1'b0, 1'b0, seen);
        REG_RDATA = 16'h5A5A; REG_ACK = 1'b1;
        tick(1);
        REG_ACK = 1'b0;
        tick(4);
        window_pulse();
        chk("pre_rst_dtack", 32'(dtack0_n), 32'd0);
        RESETn = 1'b0;
        @(negedge CLK80);
        #1;
        chk("mid_rst_dtack", 32'(dtack0_n), 32'd1);
        chk("mid_rst_doe", 32'(doe0_n), 32'd1);
        chk("mid_rst_berr", 32'(berr0_n), 32'd1);
        chk("mid_rst_dout", 32'(dout0), 32'd0);
        chk("mid_rst_regs", {7'd0, addr0, be0, wdata0}, 32'd0);
        release_bus();
        tick(3);
        RESETn = 1'b1;
        tick(3);
        $display("txn reset-in-dtack: dtack=%b doe=%b", dtack0_n, doe0_n);

        chk("dtack_berr_overlap", 32'(both_low), 32'd0);
        chk("doe_during_write", 32'(doe_wr), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
